// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: S86 I/O-space bus bundle for the UART transmit port.
// The CPU/decoder side drives strobes, select, address and write data;
// the port returns combinational read data.
interface uart_tx_port_if;
   logic [15:0] wb_dat_i;
   logic        wb_adr_i;
   logic        IOW_N;
   logic        IOR_N;
   logic        CS_N;
   logic [15:0] wb_dat_o;

   modport master (
      output wb_dat_i, wb_adr_i, IOW_N, IOR_N, CS_N,
      input  wb_dat_o
   );

   modport slave (
      input  wb_dat_i, wb_adr_i, IOW_N, IOR_N, CS_N,
      output wb_dat_o
   );
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-less I/O-space UART transmitter with a byte FIFO.
// OUT writes to DATA queue bytes; a bit-timing FSM sends them on txd,
// LSB first, back-to-back frames contiguous. STATUS/DIV register at adr 1.
// Optional macro UART_TX_PARITY_EN: 8E1 frames (even parity bit) instead of 8N1.
module uart_tx_port #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DIV_RESET  = 87
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   uart_tx_port_if.slave bus,
   output logic          txd,
   output logic          irq_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PAR,
`endif
      STOP
   } state_t;

   logic          wsel;
   logic          rsel;
   logic          wsel_q;
   logic          wr_stb;
   logic          push_req;
   logic          push;
   logic          pop;
   logic [15:0]   div;
   logic          ovf;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic [7:0]    fifo_out;

   state_t        state;
   state_t        state_n;
   logic [15:0]   baud;
   logic [15:0]   bdiv;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          tick;
   logic          txd_n;
   logic          busy;
`ifdef UART_TX_PARITY_EN
   logic          par_bit;
`endif

   logic [3:0]    level4;
   logic [15:0]   status;

   assign wsel     = ~bus.CS_N & ~bus.IOW_N;
   assign rsel     = ~bus.CS_N & ~bus.IOR_N;
   assign wr_stb   = wsel & ~wsel_q;
   assign push_req = wr_stb & ~bus.wb_adr_i;
   assign push     = push_req & ~full;

   assign empty    = (level == '0);
   assign full     = (level == LW'(FIFO_DEPTH));
   assign fifo_out = mem[rptr];

   assign busy     = (state != IDLE);
   assign tick     = (baud == bdiv - 16'd1);

   // Write-strobe edge detect, divisor register and sticky overflow flag.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wsel_q <= 1'b0;
         div    <= 16'(DIV_RESET);
         ovf    <= 1'b0;
      end else begin
         wsel_q <= wsel;
         if (wr_stb && bus.wb_adr_i) begin
            div <= (bus.wb_dat_i < 16'd2) ? 16'd2 : bus.wb_dat_i;
            ovf <= 1'b0;
         end else if (push_req && full) begin
            ovf <= 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until the level says otherwise.
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem[wptr] <= bus.wb_dat_i[7:0];
      end
   end

   // FIFO pointers and level; push and pop on one edge cancel out.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Transmit FSM state register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_n;
   end

   // Next state, FIFO pop and next serial bit.
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      txd_n   = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            txd_n = 1'b0;
            if (tick) state_n = DATA;
         end
         DATA: begin
            txd_n = shift[0];
            if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_n = PAR;
`else
               state_n = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PAR: begin
            txd_n = par_bit;
            if (tick) state_n = STOP;
         end
`endif
         STOP: begin
            if (tick) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Frame datapath: load on pop, baud counting, data shifting.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         shift   <= '0;
         bdiv    <= 16'd2;
         bit_cnt <= '0;
         baud    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else if (pop) begin
         shift   <= fifo_out;
         bdiv    <= div;
         bit_cnt <= '0;
         baud    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit <= ^fifo_out;
`endif
      end else if (state != IDLE) begin
         if (tick) begin
            baud <= '0;
            if (state == DATA) begin
               shift   <= {1'b0, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end else begin
            baud <= baud + 16'd1;
         end
      end
   end

   // Registered serial line and idle interrupt; reset forces txd high at once.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         txd   <= 1'b1;
         irq_o <= 1'b1;
      end else begin
         txd   <= txd_n;
         irq_o <= empty & ~busy;
      end
   end

   // STATUS read mux; reads have no side effects.
   always_comb begin
      level4 = 4'(level);
      status = {8'h00, ovf, busy, full, empty, level4};
      bus.wb_dat_o = (rsel && bus.wb_adr_i) ? status : '0;
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port. Bytes accepted by the
// FIFO are queued on write and compared sample-by-sample against txd.
// Honours UART_TX_PARITY_EN for 8E1 frames.
module tb_uart_tx_port;

`ifdef UART_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic txd;
   logic irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q [$];

   uart_tx_port_if bus ();

   uart_tx_port #(.FIFO_DEPTH(8), .DIV_RESET(87)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus),
      .txd      (txd),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic bus_write(input logic adr, input logic [15:0] d, input int unsigned hold);
      @(negedge clk);
      bus.wb_adr_i = adr;
      bus.wb_dat_i = d;
      bus.CS_N     = 1'b0;
      bus.IOW_N    = 1'b0;
      repeat (hold) @(negedge clk);
      bus.CS_N     = 1'b1;
      bus.IOW_N    = 1'b1;
   endtask

   task automatic write_data(input logic [7:0] d, input bit accept);
      bus_write(1'b0, {8'h00, d}, 1);
      if (accept) exp_q.push_back(d);
   endtask

   task automatic bus_read(input logic adr, output logic [15:0] d);
      @(negedge clk);
      bus.wb_adr_i = adr;
      bus.CS_N     = 1'b0;
      bus.IOR_N    = 1'b0;
      #1;
      d = bus.wb_dat_o;
      bus.CS_N     = 1'b1;
      bus.IOR_N    = 1'b1;
   endtask

   // Looks at the current sample first, then at successive falling clock edges.
   task automatic wait_start(input int unsigned limit);
      bit found;
      found = (txd === 1'b0);
      for (int unsigned i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         found = (txd === 1'b0);
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL start_bit_timeout: txd=%b after %0d cycles, expected 0", txd, limit);
      end
   endtask

   // Current negedge is the first sample of the start bit; ends on the last stop sample.
   task automatic scoreboard_frame(input int unsigned bdiv);
      logic [7:0]            b;
      logic [FRAME_BITS-1:0] bits;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got frame, expected no frame");
         return;
      end
      b = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {1'b1, b, 1'b0};
`endif
      for (int unsigned i = 0; i < FRAME_BITS * bdiv; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if (txd !== bits[i / bdiv]) begin
            n_fail++;
            $display("FAIL frame_bit byte=%h sample=%0d: txd=%b expected=%b", b, i, txd, bits[i / bdiv]);
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] st;
      bus.wb_dat_i = '0;
      bus.wb_adr_i = 1'b0;
      bus.CS_N     = 1'b1;
      bus.IOW_N    = 1'b1;
      bus.IOR_N    = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", irq); end
      n_checks++;
      if (bus.wb_dat_o !== 16'h0000) begin n_fail++; $display("FAIL reset_dat_o: got %h expected 0000", bus.wb_dat_o); end
      rst = 1'b0;
      bus_read(1'b1, st);
      n_checks++;
      if (st !== 16'h0010) begin n_fail++; $display("FAIL reset_status: got %h expected 0010", st); end
      bus_read(1'b0, st);
      n_checks++;
      if (st !== 16'h0000) begin n_fail++; $display("FAIL data_read_zero: got %h expected 0000", st); end
   endtask

   task automatic test_single_frame();
      bus_write(1'b1, 16'd4, 1);
      write_data(8'hA5, 1'b1);
      @(negedge clk);
      n_checks++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL pre_start_txd: got %b expected 1", txd); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", irq); end
      @(negedge clk);
      scoreboard_frame(4);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_during_stop: got %b expected 0", irq); end
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq); end
      n_checks++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL idle_txd: got %b expected 1", txd); end
   endtask

   task automatic test_div_min();
      bus_write(1'b1, 16'd0, 1);
      write_data(8'h5A, 1'b1);
      wait_start(10);
      scoreboard_frame(2);
      bus_write(1'b1, 16'd1, 1);
      write_data(8'hC4, 1'b1);
      wait_start(10);
      scoreboard_frame(2);
   endtask

   task automatic test_hold_strobe();
      logic [15:0] st;
      bus_write(1'b1, 16'd20, 1);
      fork
         begin
            wait_start(100);
            scoreboard_frame(20);
            @(negedge clk);
            scoreboard_frame(20);
         end
         begin
            write_data(8'h3C, 1'b1);
            bus_write(1'b0, 16'h00C3, 10);
            exp_q.push_back(8'hC3);
            bus_read(1'b1, st);
            n_checks++;
            if (st !== 16'h0041) begin n_fail++; $display("FAIL hold_status: got %h expected 0041", st); end
         end
      join
      @(negedge clk);
      n_checks++;
      if (txd !== 1'b1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_single_push: txd=%b irq=%b expected txd=1 irq=1", txd, irq);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] st;
      bus_write(1'b1, 16'd100, 1);
      fork
         begin
            wait_start(100);
            scoreboard_frame(100);
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               scoreboard_frame(4);
            end
         end
         begin
            for (int i = 0; i < 9; i++) write_data(8'h10 + 8'(i), 1'b1);
            bus_read(1'b1, st);
            n_checks++;
            if (st !== 16'h0068) begin n_fail++; $display("FAIL full_status: got %h expected 0068", st); end
            write_data(8'hEE, 1'b0);
            bus_read(1'b1, st);
            n_checks++;
            if (st !== 16'h00E8) begin n_fail++; $display("FAIL ovf_status: got %h expected 00e8", st); end
            bus_write(1'b1, 16'd4, 1);
            bus_read(1'b1, st);
            n_checks++;
            if (st !== 16'h0068) begin n_fail++; $display("FAIL ovf_clear: got %h expected 0068", st); end
         end
      join
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1 || txd !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_drained: txd=%b irq=%b expected txd=1 irq=1", txd, irq);
      end
   endtask

   task automatic test_back_to_back();
      bus_write(1'b1, 16'd3, 1);
      write_data(8'h01, 1'b1);
      write_data(8'h80, 1'b1);
      wait_start(10);
      scoreboard_frame(3);
      @(negedge clk);
      scoreboard_frame(3);
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1 || txd !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_end: txd=%b irq=%b expected txd=1 irq=1", txd, irq);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] st;
      bus_write(1'b1, 16'd4, 1);
      write_data(8'h00, 1'b1);
      write_data(8'h55, 1'b1);
      wait_start(10);
      repeat (8) @(negedge clk);
      n_checks++;
      if (txd !== 1'b0) begin n_fail++; $display("FAIL mid_frame_data: got %b expected 0", txd); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL async_reset_txd: got %b expected 1", txd); end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus_read(1'b1, st);
      n_checks++;
      if (st !== 16'h0010) begin n_fail++; $display("FAIL post_reset_status: got %h expected 0010", st); end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         n_checks++;
         if (txd !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle sample=%0d: txd=%b expected 1", i, txd); end
      end
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL post_reset_irq: got %b expected 1", irq); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      bus_write(1'b1, 16'd2, 1);
      write_data(8'h07, 1'b1);
      wait_start(10);
      scoreboard_frame(2);
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL parity_frame_len: irq=%b expected 1", irq); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_div_min();
      test_hold_strobe();
      test_overflow();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d bytes, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
